// File: rtl/attack_pkg.sv
// Shared types and default constants for the attacker scheduler.
package attack_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLR,
        ST_LAUNCH,
        ST_RUN,
        ST_OVER
    } state_t;

    typedef logic [3:0] vel_t;

    localparam int unsigned DEF_N_ATK      = 5;
    localparam int unsigned DEF_LAUNCH_GAP = 30;
    localparam int unsigned DEF_WAVE_LEN   = 20;
    localparam int unsigned DEF_BASE_XVEL  = 4;
    localparam int unsigned DEF_BASE_YVEL  = 3;
    localparam int unsigned DEF_MAX_LEVEL  = 7;

    // Base velocity plus level, clamped to the 4-bit range.
    function automatic vel_t vel_sat(input int unsigned base, input logic [2:0] lvl);
        logic [31:0] sum;
        sum = base + {29'd0, lvl};
        return (sum > 32'd15) ? 4'hF : sum[3:0];
    endfunction

endpackage

// File: rtl/atk_frame_timer.sv
// Frame tick decode and the inter-launch gap down-counter.
module atk_frame_timer
    import attack_pkg::*;
#(
    parameter int unsigned LAUNCH_GAP = DEF_LAUNCH_GAP
) (
    input  logic        i_clk,
    input  logic        i_clear,
    input  logic [16:0] i_h_count,
    input  logic [16:0] i_v_count,
    input  logic        i_reload,
    input  logic        i_dec,
    output logic        o_frame_tick,
    output logic        o_gap_zero
);

    localparam int unsigned     GAP_W      = (LAUNCH_GAP > 1) ? $clog2(LAUNCH_GAP) : 1;
    localparam logic [GAP_W-1:0] GAP_RELOAD = GAP_W'(LAUNCH_GAP - 1);

    logic [GAP_W-1:0] r_gap;

    assign o_frame_tick = (i_h_count == '0) && (i_v_count == '0);
    assign o_gap_zero   = (r_gap == '0);

    // Gap counter: reload or count down once per frame.
    always_ff @(posedge i_clk) begin
        if (i_clear) begin
            r_gap <= '0;
        end else if (o_frame_tick) begin
            if (i_reload) begin
                r_gap <= GAP_RELOAD;
            end else if (i_dec && !o_gap_zero) begin
                r_gap <= r_gap - 1'b1;
            end
        end
    end

endmodule

// File: rtl/attack_scheduler.sv
// Game sequencer: lane launch, scoring, level progression, game over.
module attack_scheduler
    import attack_pkg::*;
#(
    parameter int unsigned N_ATK      = DEF_N_ATK,
    parameter int unsigned LAUNCH_GAP = DEF_LAUNCH_GAP,
    parameter int unsigned WAVE_LEN   = DEF_WAVE_LEN,
    parameter int unsigned BASE_XVEL  = DEF_BASE_XVEL,
    parameter int unsigned BASE_YVEL  = DEF_BASE_YVEL,
    parameter int unsigned MAX_LEVEL  = DEF_MAX_LEVEL
) (
    input  logic             clk_65M,
    input  logic             clear,
    input  logic             game_on,
    input  logic [16:0]      H_count,
    input  logic [16:0]      V_count,
    input  logic [N_ATK-1:0] atk_hit,
    input  logic [N_ATK-1:0] atk_wrap,
    output logic             game_stop,
    output logic [N_ATK-1:0] atk_en,
    output logic [3:0]       atk_xvel,
    output logic [3:0]       atk_yvel,
    output logic [2:0]       level,
    output logic [15:0]      score,
    output logic             game_over
);

    localparam int unsigned       CNT_W    = $clog2(N_ATK + 1);
    localparam int unsigned       WAVE_W   = $clog2(WAVE_LEN + N_ATK + 1);
    localparam int unsigned       LANE_W   = (N_ATK > 1) ? $clog2(N_ATK) : 1;
    localparam logic [WAVE_W-1:0] WAVE_THR = WAVE_W'(WAVE_LEN);
    localparam logic [2:0]        LVL_CAP  = 3'(MAX_LEVEL);

    state_t              r_state, w_state_next;
    logic                r_game_on_prev;
    logic [N_ATK-1:0]    r_atk_en;
    logic [LANE_W-1:0]   r_lane;
    logic [15:0]         r_score;
    logic [WAVE_W-1:0]   r_wave;
    logic [2:0]          r_level;
    vel_t                r_xvel, r_yvel;

    logic                w_tick, w_gap_zero, w_reload, w_dec;
    logic                w_start, w_hit, w_last_lane;
    logic [CNT_W-1:0]    w_cnt;
    logic [16:0]         w_score_sum;
    logic [15:0]         w_score_next;
    logic [WAVE_W-1:0]   w_wave_sum, w_wave_next;
    logic [2:0]          w_level_next;

    assign w_reload = (r_state == ST_CLR) || ((r_state == ST_LAUNCH) && w_gap_zero);
    assign w_dec    = (r_state == ST_LAUNCH);

    atk_frame_timer #(
        .LAUNCH_GAP (LAUNCH_GAP)
    ) u_timer (
        .i_clk        (clk_65M),
        .i_clear      (clear),
        .i_h_count    (H_count),
        .i_v_count    (V_count),
        .i_reload     (w_reload),
        .i_dec        (w_dec),
        .o_frame_tick (w_tick),
        .o_gap_zero   (w_gap_zero)
    );

    assign w_start     = w_tick && game_on && !r_game_on_prev;
    assign w_hit       = |(atk_hit & r_atk_en);
    assign w_last_lane = (int'(r_lane) + 2 == int'(N_ATK));

    // Count wraps on enabled lanes this frame.
    always_comb begin
        w_cnt = '0;
        for (int unsigned i = 0; i < N_ATK; i++) begin
            w_cnt = w_cnt + CNT_W'(atk_wrap[i] & r_atk_en[i]);
        end
    end

    // Saturating score, wave accumulation and level step.
    always_comb begin
        w_score_sum  = {1'b0, r_score} + 17'(w_cnt);
        w_score_next = w_score_sum[16] ? 16'hFFFF : w_score_sum[15:0];
        w_wave_sum   = r_wave + WAVE_W'(w_cnt);
        w_wave_next  = w_wave_sum;
        w_level_next = r_level;
        if (w_wave_sum >= WAVE_THR) begin
            w_wave_next  = w_wave_sum - WAVE_THR;
            w_level_next = (r_level >= LVL_CAP) ? r_level : r_level + 3'd1;
        end
    end

    // State register.
    always_ff @(posedge clk_65M) begin
        if (clear) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode and state-derived outputs.
    always_comb begin
        w_state_next = r_state;
        game_stop    = 1'b0;
        game_over    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                game_stop = 1'b1;
                if (w_start) w_state_next = ST_CLR;
            end
            ST_CLR: begin
                game_stop = 1'b1;
                if (w_tick) w_state_next = (N_ATK == 1) ? ST_RUN : ST_LAUNCH;
            end
            ST_LAUNCH: begin
                if (w_tick) begin
                    if (w_hit) begin
                        w_state_next = ST_OVER;
                    end else if (w_gap_zero && w_last_lane) begin
                        w_state_next = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (w_tick && w_hit) w_state_next = ST_OVER;
            end
            ST_OVER: begin
                game_over = 1'b1;
                if (w_start) w_state_next = ST_CLR;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Frame-rate datapath: start history, lane enables, score, level, velocities.
    always_ff @(posedge clk_65M) begin
        if (clear) begin
            r_game_on_prev <= 1'b1;
            r_atk_en       <= '0;
            r_lane         <= '0;
            r_score        <= '0;
            r_wave         <= '0;
            r_level        <= '0;
            r_xvel         <= vel_sat(BASE_XVEL, 3'd0);
            r_yvel         <= vel_sat(BASE_YVEL, 3'd0);
        end else if (w_tick) begin
            r_game_on_prev <= game_on;
            if (w_state_next == ST_CLR) begin
                r_atk_en <= '0;
                r_lane   <= '0;
                r_score  <= '0;
                r_wave   <= '0;
                r_level  <= '0;
                r_xvel   <= vel_sat(BASE_XVEL, 3'd0);
                r_yvel   <= vel_sat(BASE_YVEL, 3'd0);
            end else if (r_state == ST_CLR) begin
                r_atk_en <= N_ATK'(1);
            end else if ((r_state == ST_LAUNCH || r_state == ST_RUN) && !w_hit) begin
                r_score <= w_score_next;
                r_wave  <= w_wave_next;
                r_level <= w_level_next;
                r_xvel  <= vel_sat(BASE_XVEL, w_level_next);
                r_yvel  <= vel_sat(BASE_YVEL, w_level_next);
                if (r_state == ST_LAUNCH && w_gap_zero) begin
                    r_atk_en <= (r_atk_en << 1) | N_ATK'(1);
                    r_lane   <= r_lane + LANE_W'(1);
                end
            end
        end
    end

    assign atk_en   = r_atk_en;
    assign score    = r_score;
    assign level    = r_level;
    assign atk_xvel = r_xvel;
    assign atk_yvel = r_yvel;

endmodule

// File: tb/tb_attack_scheduler.sv
// Directed bench for attack_scheduler with hand-computed expectations.
module tb_attack_scheduler;

    logic        clk_65M = 1'b0;
    logic        clear;
    logic        game_on;
    logic [16:0] H_count, V_count;
    logic [4:0]  atk_hit, atk_wrap;
    logic        game_stop, game_over;
    logic [4:0]  atk_en;
    logic [3:0]  atk_xvel, atk_yvel;
    logic [2:0]  level;
    logic [15:0] score;

    int n_checks = 0;
    int n_fail   = 0;

    attack_scheduler #(
        .N_ATK      (5),
        .LAUNCH_GAP (30),
        .WAVE_LEN   (20),
        .BASE_XVEL  (4),
        .BASE_YVEL  (3),
        .MAX_LEVEL  (7)
    ) dut (
        .clk_65M   (clk_65M),
        .clear     (clear),
        .game_on   (game_on),
        .H_count   (H_count),
        .V_count   (V_count),
        .atk_hit   (atk_hit),
        .atk_wrap  (atk_wrap),
        .game_stop (game_stop),
        .atk_en    (atk_en),
        .atk_xvel  (atk_xvel),
        .atk_yvel  (atk_yvel),
        .level     (level),
        .score     (score),
        .game_over (game_over)
    );

    always #5 clk_65M = ~clk_65M;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One frame-tick edge followed by a non-tick edge; returns on a negedge.
    task automatic tick();
        @(negedge clk_65M);
        H_count = 17'd0;
        V_count = 17'd0;
        @(negedge clk_65M);
        H_count = 17'd100;
        V_count = 17'd3;
        @(negedge clk_65M);
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic check_reset_outs(input string pfx);
        check_eq({pfx, "_stop"},  32'(game_stop), 32'd1);
        check_eq({pfx, "_en"},    32'(atk_en),    32'd0);
        check_eq({pfx, "_over"},  32'(game_over), 32'd0);
        check_eq({pfx, "_level"}, 32'(level),     32'd0);
        check_eq({pfx, "_score"}, 32'(score),     32'd0);
        check_eq({pfx, "_xvel"},  32'(atk_xvel),  32'd4);
        check_eq({pfx, "_yvel"},  32'(atk_yvel),  32'd3);
    endtask

    initial begin
        clear    = 1'b1;
        game_on  = 1'b1;
        H_count  = 17'd100;
        V_count  = 17'd3;
        atk_hit  = '0;
        atk_wrap = '0;
        tick();
        @(negedge clk_65M);
        clear = 1'b0;
        check_reset_outs("rst");

        // game_on held high through reset must not start a game
        tick();
        check_eq("held_on_stop", 32'(game_stop), 32'd1);
        check_eq("held_on_en",   32'(atk_en),    32'd0);

        game_on = 1'b0;
        tick();
        game_on = 1'b1;
        tick();
        check_eq("clr_stop", 32'(game_stop), 32'd1);
        check_eq("clr_en",   32'(atk_en),    32'd0);

        tick();
        check_eq("launch_stop", 32'(game_stop), 32'd0);
        check_eq("launch_en0",  32'(atk_en),    32'd1);

        for (int r = 1; r <= 4; r++) begin
            for (int j = 0; j < 29; j++) begin
                if (r == 2 && j == 0) begin
                    atk_hit  = 5'b10000;
                    atk_wrap = 5'b01000;
                end
                tick();
                atk_hit  = '0;
                atk_wrap = '0;
            end
            check_eq("launch_hold", 32'(atk_en), 32'((1 << r) - 1));
            tick();
            check_eq("launch_step", 32'(atk_en), 32'((1 << (r + 1)) - 1));
            check_eq("launch_over", 32'(game_over), 32'd0);
        end
        check_eq("launch_score", 32'(score), 32'd0);

        // start while running is ignored
        game_on = 1'b0;
        tick();
        game_on = 1'b1;
        tick();
        check_eq("run_restart_en",   32'(atk_en),    32'd31);
        check_eq("run_restart_stop", 32'(game_stop), 32'd0);

        atk_wrap = 5'b00001;
        ticks(19);
        check_eq("w19_score", 32'(score), 32'd19);
        check_eq("w19_level", 32'(level), 32'd0);
        tick();
        atk_wrap = '0;
        check_eq("w20_score", 32'(score),    32'd20);
        check_eq("w20_level", 32'(level),    32'd1);
        check_eq("w20_xvel",  32'(atk_xvel), 32'd5);
        check_eq("w20_yvel",  32'(atk_yvel), 32'd4);

        atk_wrap = 5'b11111;
        ticks(24);
        check_eq("lv7_level", 32'(level),    32'd7);
        check_eq("lv7_xvel",  32'(atk_xvel), 32'd11);
        check_eq("lv7_yvel",  32'(atk_yvel), 32'd10);
        check_eq("lv7_score", 32'(score),    32'd140);
        ticks(8);
        atk_wrap = '0;
        check_eq("sat_level", 32'(level),    32'd7);
        check_eq("sat_xvel",  32'(atk_xvel), 32'd11);
        check_eq("sat_score", 32'(score),    32'd180);

        atk_hit  = 5'b00100;
        atk_wrap = 5'b00001;
        tick();
        atk_hit  = '0;
        atk_wrap = '0;
        check_eq("hit_over",  32'(game_over), 32'd1);
        check_eq("hit_score", 32'(score),     32'd180);
        check_eq("hit_level", 32'(level),     32'd7);
        check_eq("hit_en",    32'(atk_en),    32'd31);

        atk_wrap = 5'b11111;
        ticks(2);
        atk_wrap = '0;
        check_eq("over_score", 32'(score),     32'd180);
        check_eq("over_flag",  32'(game_over), 32'd1);
        check_eq("over_en",    32'(atk_en),    32'd31);

        game_on = 1'b0;
        tick();
        game_on = 1'b1;
        tick();
        check_eq("reclr_over",  32'(game_over), 32'd0);
        check_eq("reclr_stop",  32'(game_stop), 32'd1);
        check_eq("reclr_score", 32'(score),     32'd0);
        check_eq("reclr_level", 32'(level),     32'd0);
        check_eq("reclr_xvel",  32'(atk_xvel),  32'd4);
        check_eq("reclr_en",    32'(atk_en),    32'd0);

        tick();
        check_eq("relaunch_en", 32'(atk_en), 32'd1);
        ticks(120);
        check_eq("rerun_en", 32'(atk_en), 32'd31);

        atk_wrap = 5'b00010;
        ticks(13);
        atk_wrap = '0;
        check_eq("pre_clear_score", 32'(score), 32'd13);

        // clear on a non-tick edge
        @(negedge clk_65M);
        clear = 1'b1;
        @(negedge clk_65M);
        check_reset_outs("clr_mid");
        clear = 1'b0;

        tick();
        check_eq("post_clear_stop", 32'(game_stop), 32'd1);
        check_eq("post_clear_en",   32'(atk_en),    32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/attack_scheduler.md
ATTACK_SCHEDULER -- requirements
Module: attack_scheduler

Interface
REQ-001 The block SHALL have parameter N_ATK, default 5, meaning number of attacker lanes sequenced.
REQ-002 The block SHALL have parameter LAUNCH_GAP, default 30, meaning frames between successive lane launches.
REQ-003 The block SHALL have parameter WAVE_LEN, default 20, meaning attacker wraps per level.
REQ-004 The block SHALL have parameters BASE_XVEL, default 4, and BASE_YVEL, default 3, meaning level-0 velocities.
REQ-005 The block SHALL have parameter MAX_LEVEL, default 7, meaning saturating level ceiling.
REQ-006 The block SHALL have port clk_65M, input, 1 bit, meaning the single system clock.
REQ-007 The block SHALL have port clear, input, 1 bit, meaning reset, synchronous and active-high.
REQ-008 The block SHALL have port game_on, input, 1 bit, meaning player start level; a rising edge starts a game.
REQ-009 The block SHALL have ports H_count and V_count, input, 17 bits each, meaning raster position.
REQ-010 The block SHALL have port atk_hit, input, N_ATK bits, meaning per-lane collision flag (lane gameN_over).
REQ-011 The block SHALL have port atk_wrap, input, N_ATK bits, meaning per-lane wall-reached indication, sampled at frame tick.
REQ-012 The block SHALL have port game_stop, output, 1 bit, meaning attacker position/flag reset command.
REQ-013 The block SHALL have port atk_en, output, N_ATK bits, meaning per-lane enable.
REQ-014 The block SHALL have ports atk_xvel and atk_yvel, output, 4 bits each, meaning current velocities.
REQ-015 The block SHALL have port level, output, 3 bits, meaning current level.
REQ-016 The block SHALL have port score, output, 16 bits, meaning wraps survived.
REQ-017 The block SHALL have port game_over, output, 1 bit, meaning a collision has ended the game.

Function
REQ-018 frame_tick SHALL be true when H_count==0 and V_count==0; every state change, counter update and sampling of atk_hit/atk_wrap SHALL occur only on a clock edge where frame_tick is true.
REQ-019 game_on SHALL be registered once per frame_tick; "start" SHALL mean sampled 1 with previous sample 0.
REQ-020 The FSM SHALL have states IDLE, CLR, LAUNCH, RUN and OVER.
REQ-021 IDLE SHALL assert game_stop=1 and atk_en=0, and SHALL go to CLR on start.
REQ-022 CLR SHALL last exactly one frame with game_stop=1, zero level, score and lane index, then go to LAUNCH.
REQ-023 In LAUNCH, game_stop SHALL be 0, and lane 0 SHALL be enabled on CLR exit.
REQ-024 In LAUNCH, each subsequent lane SHALL be enabled LAUNCH_GAP frames after the previous one; enables SHALL be cumulative, lane i never before lane i-1.
REQ-025 When all N_ATK lanes are enabled, the FSM SHALL go to RUN.
REQ-026 In LAUNCH or RUN, score SHALL increment by popcount(atk_wrap & atk_en) each tick and SHALL saturate at 16'hFFFF.
REQ-027 In LAUNCH or RUN, a wave counter SHALL accumulate the same count; on reaching >=WAVE_LEN it SHALL subtract WAVE_LEN and increment level, saturating at MAX_LEVEL.
REQ-028 atk_xvel SHALL equal BASE_XVEL+level and atk_yvel SHALL equal BASE_YVEL+level, each saturating at 4'hF, registered and updated the same tick as level.
REQ-029 If (atk_hit & atk_en) is nonzero at a tick in LAUNCH or RUN, the FSM SHALL go to OVER.
REQ-030 On a tick with both hit and wrap, the hit SHALL win and score and level SHALL NOT change that tick.
REQ-031 OVER SHALL hold game_over=1, atk_en frozen at its entry value, and score and level frozen.
REQ-032 OVER SHALL go to CLR on start, where game_over SHALL clear.
REQ-033 game_over SHALL be 0 in every state other than OVER.
REQ-034 Start while in LAUNCH or RUN SHALL be ignored.

Reset
REQ-035 clear=1 at a clock edge SHALL force IDLE regardless of frame_tick, including mid-LAUNCH, mid-RUN and in OVER.
REQ-036 Reset values SHALL be: game_stop=1, atk_en=0, game_over=0, level=0, score=0, atk_xvel=BASE_XVEL, atk_yvel=BASE_YVEL, and gap, wave and lane counters 0.
REQ-037 The game_on history register SHALL reset to 1, so that game_on held high through reset does not start a game.

Structure
REQ-038 A shared package attack_pkg SHALL hold the state enum, the default parameter constants and the 4-bit velocity type.
REQ-039 One sub-module, atk_frame_timer, SHALL generate frame_tick and the LAUNCH_GAP down-counter with a reload input.
REQ-040 All other logic SHALL reside in attack_scheduler.

Verification
REQ-041 Reset, then toggle game_on 0->1 -> required: CLR for 1 frame with game_stop=1, then atk_en=00001, 00011 30 frames later, and 11111 after 120 frames in LAUNCH, then RUN.
REQ-042 In RUN, pulse one atk_wrap bit on 20 ticks -> required: score=20, level=1, xvel=5, yvel=3+1=4.
REQ-043 Force 8 waves -> required: level saturates at 7, xvel=11.
REQ-044 Same tick, atk_hit[2]=1 and atk_wrap[0]=1 -> required: OVER, game_over=1, score unchanged; a later start gives CLR and game_over=0.
REQ-045 atk_hit on a not-yet-enabled lane during LAUNCH -> required: ignored, no OVER.
REQ-046 clear=1 mid-RUN with score=13 -> required: next edge IDLE, all outputs at reset values.
